// File: rtl/des_subkey_sequencer_pkg.sv
// des_subkey_sequencer_pkg
// Shared DES key-schedule constants and helpers: PC1/PC2 selection tables,
// the per-round left-shift schedule, bus widths, the sequencer state type
// and 28-bit half rotations. Bit numbering follows DES: bit 1 is the MSB.
package des_subkey_sequencer_pkg;

    localparam int DES_KEY_W    = 64;
    localparam int DES_CD_W     = 56;
    localparam int DES_HALF_W   = 28;
    localparam int DES_SUBKEY_W = 48;
    localparam int DES_ROUNDS   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // PC1: CD bit i+1 takes key bit PC1_TAB[i]
    localparam int PC1_TAB [DES_CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC2: subkey bit i+1 takes CD bit PC2_TAB[i]
    localparam int PC2_TAB [DES_SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left shift applied to produce C(n)D(n) from C(n-1)D(n-1); entry n-1
    localparam int SHIFT_TAB [DES_ROUNDS] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    function automatic logic [1:DES_CD_W] pc1(input logic [1:DES_KEY_W] k);
        logic [1:DES_CD_W] r;
        r = '0;
        for (int i = 0; i < DES_CD_W; i++) begin
            r[i+1] = k[PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic int shift_amt(input logic [3:0] idx);
        return SHIFT_TAB[idx];
    endfunction

    function automatic logic [1:DES_HALF_W] rotl28(input logic [1:DES_HALF_W] h, input int n);
        return (h << n) | (h >> (DES_HALF_W - n));
    endfunction

    function automatic logic [1:DES_HALF_W] rotr28(input logic [1:DES_HALF_W] h, input int n);
        return (h >> n) | (h << (DES_HALF_W - n));
    endfunction

endpackage

// File: rtl/des_subkey_sequencer_if.sv
// des_subkey_sequencer_if
// Key-in and subkey-out valid/ready channels of the subkey sequencer.
//   key_valid/key_ready/key/decrypt         : key load channel (upstream -> sequencer)
//   subkey_valid/subkey_ready/subkey/round/last : subkey stream (sequencer -> round datapath)
// master = the side driving keys and consuming subkeys; slave = the sequencer.
interface des_subkey_sequencer_if;
    import des_subkey_sequencer_pkg::*;

    logic                    key_valid;
    logic                    key_ready;
    logic [1:DES_KEY_W]      key;
    logic                    decrypt;
    logic                    subkey_valid;
    logic                    subkey_ready;
    logic [1:DES_SUBKEY_W]   subkey;
    logic [4:0]              round;
    logic                    last;

    modport master (
        output key_valid, key, decrypt, subkey_ready,
        input  key_ready, subkey_valid, subkey, round, last
    );

    modport slave (
        input  key_valid, key, decrypt, subkey_ready,
        output key_ready, subkey_valid, subkey, round, last
    );

endinterface

// File: rtl/des_subkey_sequencer_pc2.sv
// des_subkey_sequencer_pc2
// Combinational DES permuted choice 2: selects 48 of the 56 CD bits.
//   i_cd     [1:56] concatenated C/D halves, bit 1 = MSB
//   o_subkey [1:48] round subkey, bit 1 = MSB
module des_subkey_sequencer_pc2
    import des_subkey_sequencer_pkg::*;
(
    input  logic [1:DES_CD_W]     i_cd,
    output logic [1:DES_SUBKEY_W] o_subkey
);

    // PC2 discards these CD positions by definition
    logic w_unused_dropped;
    assign w_unused_dropped = ^{i_cd[9], i_cd[18], i_cd[22], i_cd[25],
                                i_cd[35], i_cd[38], i_cd[43], i_cd[54]};

    always_comb begin
        o_subkey = '0;
        for (int i = 0; i < DES_SUBKEY_W; i++) begin
            o_subkey[i+1] = i_cd[PC2_TAB[i]];
        end
    end

endmodule

// File: rtl/des_subkey_sequencer.sv
// des_subkey_sequencer
// Iterative DES key schedule: loads one key and streams its 16 subkeys, one
// per accepted beat, in encrypt (K1..K16) or decrypt (K16..K1) order.
//   i_clk   : clock, rising edge
//   i_reset : synchronous, active-high
//   s_if    : slave side of des_subkey_sequencer_if (key in, subkey stream out)
//
// state   | meaning
// ST_IDLE | no key held; key_ready high, subkey_valid low
// ST_RUN  | CD holds the current round's halves; subkey_valid high
module des_subkey_sequencer
    import des_subkey_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
)(
    input  logic                  i_clk,
    input  logic                  i_reset,
    des_subkey_sequencer_if.slave s_if
);

    localparam int ROUND_W = 5;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    seq_state_t          r_state, w_state_nxt;
    logic [1:DES_CD_W]   r_cd, w_cd_nxt;
    logic [ROUND_W-1:0]  r_round, w_round_nxt;
    logic                r_dir, w_dir_nxt;

    logic                w_last;
    logic                w_xfer;
    logic                w_key_ready;
    logic                w_load;
    logic [1:DES_CD_W]   w_pc1;
    logic [3:0]          w_sidx;
    int                  w_shift;
    logic [1:DES_SUBKEY_W] w_subkey;

    assign w_last      = (r_state == ST_RUN) && (r_round == LAST_ROUND);
    assign w_xfer      = (r_state == ST_RUN) && s_if.subkey_ready;
    // Ready during the final transfer lets the next key follow with no bubble
    assign w_key_ready = (r_state == ST_IDLE) || (w_xfer && w_last);
    assign w_load      = s_if.key_valid && w_key_ready;
    assign w_pc1       = pc1(s_if.key);

    // Encrypt steps to K(round+1): S[round+1] is table entry round.
    // Decrypt steps back to K(16-round) by undoing S[17-round], entry 16-round.
    assign w_sidx  = r_dir ? 4'(LAST_ROUND - r_round) : r_round[3:0];
    assign w_shift = shift_amt(w_sidx);

    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_cd;
        w_round_nxt = r_round;
        w_dir_nxt   = r_dir;
        if (w_load) begin
            w_state_nxt = ST_RUN;
            w_round_nxt = ROUND_W'(1);
            w_dir_nxt   = s_if.decrypt;
            // Total rotation over 16 rounds is 28, so C16D16 equals PC1(key)
            if (s_if.decrypt) begin
                w_cd_nxt = w_pc1;
            end else begin
                w_cd_nxt = {rotl28(w_pc1[1:28], 1), rotl28(w_pc1[29:56], 1)};
            end
        end else if (w_xfer) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_round_nxt = '0;
            end else begin
                w_round_nxt = r_round + ROUND_W'(1);
                if (r_dir) begin
                    w_cd_nxt = {rotr28(r_cd[1:28], w_shift), rotr28(r_cd[29:56], w_shift)};
                end else begin
                    w_cd_nxt = {rotl28(r_cd[1:28], w_shift), rotl28(r_cd[29:56], w_shift)};
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cd    <= '0;
            r_round <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cd    <= w_cd_nxt;
            r_round <= w_round_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    des_subkey_sequencer_pc2 u_pc2 (
        .i_cd     (r_cd),
        .o_subkey (w_subkey)
    );

    assign s_if.key_ready    = w_key_ready;
    assign s_if.subkey_valid = (r_state == ST_RUN);
    assign s_if.subkey       = w_subkey;
    assign s_if.round        = r_round;
    assign s_if.last         = w_last;

endmodule

// File: tb/tb_des_subkey_sequencer.sv
`timescale 1ns/1ps
module tb_des_subkey_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    des_subkey_sequencer_if u_if();

    des_subkey_sequencer dut (
        .i_clk   (clk),
        .i_reset (reset),
        .s_if    (u_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] KEY_1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_A = 64'h123456789ABCDEF0;
    localparam logic [63:0] PAR_M = 64'h0101010101010101;

    // Published subkeys K1..K16 of key 133457799BBCDFF1
    logic [47:0] K_TAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    // Reference: parallel key schedule using cumulative shifts
    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int TB_CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    function automatic logic [55:0] m_pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-TB_PC1[i]];
        return r;
    endfunction

    function automatic logic [27:0] m_rotl(input logic [27:0] h, input int s);
        return (h << s) | (h >> (28 - s));
    endfunction

    function automatic logic [47:0] m_subkey(input logic [63:0] k, input int n);
        logic [55:0] cd;
        logic [55:0] cdn;
        logic [47:0] r;
        cd  = m_pc1(k);
        cdn = {m_rotl(cd[55:28], TB_CUM[n-1]), m_rotl(cd[27:0], TB_CUM[n-1])};
        r   = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cdn[56-TB_PC2[i]];
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [47:0] got_k [16];
    logic [4:0]  got_r [16];
    logic        got_l [16];
    int          got_n;
    int          got_cyc;

    // Runs at negedges; ready is random with stall_pct % probability of 0
    task automatic capture(input int stall_pct);
        logic        stalled;
        logic [47:0] p_k;
        logic [4:0]  p_r;
        logic        rdy;
        stalled = 1'b0;
        p_k = '0;
        p_r = '0;
        got_n = 0;
        got_cyc = 0;
        while (got_n < 16 && got_cyc < 400) begin
            if (stalled) begin
                check_val("stall_valid",  64'(u_if.subkey_valid), 64'd1);
                check_val("stall_subkey", 64'(u_if.subkey), 64'(p_k));
                check_val("stall_round",  64'(u_if.round), 64'(p_r));
            end
            rdy = (int'($urandom_range(99)) >= stall_pct);
            u_if.subkey_ready = rdy;
            if (u_if.subkey_valid && rdy) begin
                got_k[got_n] = u_if.subkey;
                got_r[got_n] = u_if.round;
                got_l[got_n] = u_if.last;
                got_n++;
            end
            stalled = u_if.subkey_valid && !rdy;
            p_k = u_if.subkey;
            p_r = u_if.round;
            @(negedge clk);
            got_cyc++;
        end
        u_if.subkey_ready = 1'b0;
        check_val("stream_beats", 64'(got_n), 64'd16);
    endtask

    task automatic load_key(input logic [63:0] k, input logic dec);
        u_if.key       = k;
        u_if.decrypt   = dec;
        u_if.key_valid = 1'b1;
        @(negedge clk);
        u_if.key_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_valid"}, 64'(u_if.subkey_valid), 64'd0);
        check_val({tag, "_round"}, 64'(u_if.round), 64'd0);
        check_val({tag, "_last"},  64'(u_if.last), 64'd0);
        check_val({tag, "_kready"}, 64'(u_if.key_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        u_if.key_valid    = 1'b0;
        u_if.key          = '0;
        u_if.decrypt      = 1'b0;
        u_if.subkey_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("rst");
        check_val("rst_subkey", 64'(u_if.subkey), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: encrypt, always ready
        check_val("t1_kready", 64'(u_if.key_ready), 64'd1);
        load_key(KEY_1, 1'b0);
        capture(0);
        check_val("t1_cycles", 64'(got_cyc), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("t1_k%0d", i + 1), 64'(got_k[i]), 64'(K_TAB[i]));
            check_val($sformatf("t1_r%0d", i + 1), 64'(got_r[i]), 64'(i + 1));
            check_val($sformatf("t1_l%0d", i + 1), 64'(got_l[i]), 64'(i == 15));
        end
        check_val("t1_cd_inv", 64'(dut.r_cd), 64'(m_pc1(KEY_1)));
        check_idle("t1_idle");

        // 2: decrypt, reverse order
        load_key(KEY_1, 1'b1);
        capture(0);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("t2_k%0d", i + 1), 64'(got_k[i]), 64'(K_TAB[15-i]));
            check_val($sformatf("t2_r%0d", i + 1), 64'(got_r[i]), 64'(i + 1));
        end
        check_val("t2_last16", 64'(got_l[15]), 64'd1);

        // 3: random stalls
        load_key(KEY_1, 1'b0);
        capture(50);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("t3_k%0d", i + 1), 64'(got_k[i]), 64'(K_TAB[i]));
            check_val($sformatf("t3_r%0d", i + 1), 64'(got_r[i]), 64'(i + 1));
        end

        // 4: back-to-back, second key (decrypt) during round-16 transfer
        load_key(KEY_1, 1'b0);
        u_if.subkey_ready = 1'b1;
        for (int b = 1; b <= 16; b++) begin
            if (b == 15) check_val("t4_kready_r15", 64'(u_if.key_ready), 64'd0);
            if (b == 16) begin
                check_val("t4_last16", 64'(u_if.last), 64'd1);
                check_val("t4_kready_r16", 64'(u_if.key_ready), 64'd1);
                u_if.key       = KEY_A;
                u_if.decrypt   = 1'b1;
                u_if.key_valid = 1'b1;
            end
            @(negedge clk);
        end
        u_if.key_valid = 1'b0;
        check_val("t4_valid", 64'(u_if.subkey_valid), 64'd1);
        check_val("t4_round", 64'(u_if.round), 64'd1);
        check_val("t4_subkey", 64'(u_if.subkey), 64'(m_subkey(KEY_A, 16)));
        check_val("t4_kready_after", 64'(u_if.key_ready), 64'd0);
        capture(0);
        check_val("t4_beat2", 64'(got_k[1]), 64'(m_subkey(KEY_A, 15)));
        check_val("t4_beat16", 64'(got_k[15]), 64'(m_subkey(KEY_A, 1)));

        // 5: ignored key while running, then reset at round 7 during a stall
        load_key(KEY_1, 1'b0);
        u_if.subkey_ready = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            if (b == 3) begin
                check_val("t5_kready_busy", 64'(u_if.key_ready), 64'd0);
                u_if.key       = KEY_A;
                u_if.decrypt   = 1'b1;
                u_if.key_valid = 1'b1;
            end
            if (b == 4) begin
                u_if.key_valid = 1'b0;
                check_val("t5_r4_round", 64'(u_if.round), 64'd4);
                check_val("t5_r4_subkey", 64'(u_if.subkey), 64'(K_TAB[3]));
            end
            @(negedge clk);
        end
        u_if.subkey_ready = 1'b0;
        check_val("t5_r7_round", 64'(u_if.round), 64'd7);
        check_val("t5_r7_subkey", 64'(u_if.subkey), 64'(K_TAB[6]));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("t5_rst");
        check_val("t5_rst_subkey", 64'(u_if.subkey), 64'd0);
        load_key(KEY_1, 1'b0);
        check_val("t5_reload_round", 64'(u_if.round), 64'd1);
        check_val("t5_reload_k1", 64'(u_if.subkey), 64'(K_TAB[0]));
        capture(0);
        check_val("t5_reload_k16", 64'(got_k[15]), 64'(K_TAB[15]));

        // 6: parity bits do not matter
        load_key(KEY_A, 1'b0);
        capture(0);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("t6a_k%0d", i + 1), 64'(got_k[i]), 64'(m_subkey(KEY_A, i + 1)));
        check_val("t6a_cd_inv", 64'(dut.r_cd), 64'(m_pc1(KEY_A)));
        load_key(KEY_A ^ PAR_M, 1'b0);
        capture(25);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("t6b_k%0d", i + 1), 64'(got_k[i]), 64'(m_subkey(KEY_A, i + 1)));
        check_val("t6b_cd_inv", 64'(dut.r_cd), 64'(m_pc1(KEY_A)));
        check_idle("t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
